alu_md: RTL

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_pkg.sv | 58 +++++
 rtl/alu_md_base.sv | 37 +++
 rtl/alu_md.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_pkg.sv
// Shared definitions for alu_md: operation codes, FSM states and operation-class helpers.
package alu_md_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_SLL    = 5'h01,
        ALU_SLT    = 5'h02,
        ALU_SLTU   = 5'h03,
        ALU_XOR    = 5'h04,
        ALU_SRL    = 5'h05,
        ALU_OR     = 5'h06,
        ALU_AND    = 5'h07,
        ALU_SUB    = 5'h08,
        ALU_SRA    = 5'h0D,
        ALU_LUI    = 5'h0F,
        ALU_MUL    = 5'h10,
        ALU_MULH   = 5'h11,
        ALU_MULHSU = 5'h12,
        ALU_MULHU  = 5'h13,
        ALU_DIV    = 5'h14,
        ALU_DIVU   = 5'h15,
        ALU_REM    = 5'h16,
        ALU_REMU   = 5'h17
    } alu_func_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    function automatic logic is_mul(input logic [4:0] f);
        return f[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [4:0] f);
        return f[4:2] == 3'b101;
    endfunction

    // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic mul_op1_signed(input logic [4:0] f);
        return (f == ALU_MULH) || (f == ALU_MULHSU);
    endfunction

    function automatic logic mul_op2_signed(input logic [4:0] f);
        return f == ALU_MULH;
    endfunction

    function automatic logic div_signed(input logic [4:0] f);
        return (f == ALU_DIV) || (f == ALU_REM);
    endfunction

    function automatic logic div_wants_quot(input logic [4:0] f);
        return (f == ALU_DIV) || (f == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_base.sv
// Combinational single-cycle ALU operations; legal is low for any code it does not handle.
module alu_md_base
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            legal
);
    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        res   = '0;
        legal = 1'b1;
        case (func)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $signed(a) >>> shamt;
            ALU_XOR:  res = a ^ b;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
            ALU_LUI:  res = b;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_md.sv
// Iterative ALU with shift-add multiplier and, when ALU_MD_DIV_EN is defined, a restoring divider.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      alu_func,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            out_illegal
);
    localparam int SHAMT_W = $clog2(XLEN);

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]          func_q, func_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                neg_q, neg_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     alu_out_q, alu_out_d;
    logic                out_illegal_q, out_illegal_d;

    logic [XLEN-1:0]     base_res;
    logic                base_legal;

    alu_md_base #(.XLEN(XLEN)) u_base (
        .func  (alu_func),
        .a     (op1),
        .b     (op2),
        .res   (base_res),
        .legal (base_legal)
    );

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // prod_q holds {partial product, remaining multiplier bits}; one bit retires per cycle.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nx;
    logic [2*XLEN-1:0]   mul_fix;
    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, prod_q[0] ? mcand_q : {XLEN{1'b0}}};
    assign mul_nx  = {mul_sum, prod_q[XLEN-1:1]};
    assign mul_fix = neg_q ? -mul_nx : mul_nx;

`ifdef ALU_MD_DIV_EN
    // prod_q holds {remainder, dividend bits still to shift in / quotient bits so far}.
    logic                neg_r_q, neg_r_d;
    logic                div_sgn, div_ovf;
    logic [XLEN:0]       div_sh, div_diff;
    logic [2*XLEN-1:0]   div_nx;
    logic [XLEN-1:0]     div_qfix, div_rfix;
    assign div_sgn  = div_signed(alu_func);
    assign div_ovf  = div_sgn && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
    assign div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand_q};
    assign div_nx   = div_diff[XLEN] ? {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign div_qfix = neg_q   ? -div_nx[XLEN-1:0]      : div_nx[XLEN-1:0];
    assign div_rfix = neg_r_q ? -div_nx[2*XLEN-1:XLEN] : div_nx[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        func_d        = func_q;
        mcand_d       = mcand_q;
        prod_d        = prod_q;
        neg_d         = neg_q;
        out_valid_d   = out_valid_q;
        alu_out_d     = alu_out_q;
        out_illegal_d = out_illegal_q;
`ifdef ALU_MD_DIV_EN
        neg_r_d       = neg_r_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    func_d        = alu_func;
                    out_illegal_d = 1'b0;
                    if (base_legal) begin
                        alu_out_d   = base_res;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (is_mul(alu_func)) begin
                        mcand_d = mag(op1, mul_op1_signed(alu_func));
                        prod_d  = {{XLEN{1'b0}}, mag(op2, mul_op2_signed(alu_func))};
                        neg_d   = (mul_op1_signed(alu_func) & op1[XLEN-1])
                                ^ (mul_op2_signed(alu_func) & op2[XLEN-1]);
                        cnt_d   = SHAMT_W'(XLEN-1);
                        state_d = S_MUL;
                    end
`ifdef ALU_MD_DIV_EN
                    else if (is_div(alu_func)) begin
                        if (op2 == '0) begin
                            alu_out_d   = div_wants_quot(alu_func) ? {XLEN{1'b1}} : op1;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else if (div_ovf) begin
                            alu_out_d   = div_wants_quot(alu_func) ? op1 : '0;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            mcand_d = mag(op2, div_sgn);
                            prod_d  = {{XLEN{1'b0}}, mag(op1, div_sgn)};
                            neg_d   = div_sgn & (op1[XLEN-1] ^ op2[XLEN-1]);
                            neg_r_d = div_sgn & op1[XLEN-1];
                            cnt_d   = SHAMT_W'(XLEN-1);
                            state_d = S_DIV;
                        end
                    end
`endif
                    else begin
                        alu_out_d     = '0;
                        out_illegal_d = 1'b1;
                        out_valid_d   = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_nx;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d       = '0;
                    alu_out_d   = (func_q == ALU_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DIV: begin
`ifdef ALU_MD_DIV_EN
                prod_d = div_nx;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d       = '0;
                    alu_out_d   = div_wants_quot(func_q) ? div_qfix : div_rfix;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            out_valid_d   = 1'b0;
            alu_out_d     = '0;
            out_illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            alu_out_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            alu_out_q     <= alu_out_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Datapath registers are only meaningful while a MUL/DIV runs, so they carry no reset.
    always_ff @(posedge clk) begin
        func_q  <= func_d;
        mcand_q <= mcand_d;
        prod_q  <= prod_d;
        neg_q   <= neg_d;
`ifdef ALU_MD_DIV_EN
        neg_r_q <= neg_r_d;
`endif
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign alu_out     = alu_out_q;
    assign out_illegal = out_illegal_q;

endmodule
